// File: rtl/dpwm_deadtime_dither.sv
// Dead-time digital PWM with optional duty dither.
// One period is 2^CNT_W clocks. The high side is on for count values in
// [dt_lead, d_eff). The low side is on for count values in
// [d_eff + dt_trail, T). Because the low-side window starts at or after
// d_eff, the two windows can never overlap.
// Macro DPWM_DITHER_EN adds a fractional-duty accumulator. Its carry
// stretches d_eff by one clock in selected periods.
// Without the macro, duty_frac is ignored and the dither bit is 0.

// Half-open range compare [lo, hi) on an extended-width count.
module dpwm_window #(
  parameter int W = 7
) (
  input  logic [W-1:0] c,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         hit
);
  assign hit = (c >= lo) && (c < hi);
endmodule

module dpwm_deadtime_dither #(
  parameter int CNT_W  = 6,
  parameter int DITH_W = 2,
  parameter int DT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  duty_int,
  input  logic [DITH_W-1:0] duty_frac,
  input  logic [DT_W-1:0]   dt_lead,
  input  logic [DT_W-1:0]   dt_trail,
  input  logic              fault,
  input  logic              fault_clr,
  output logic              hs_out,
  output logic              ls_out,
  output logic [CNT_W-1:0]  count,
  output logic              period_start,
  output logic              fault_latched
);

  localparam int XW = CNT_W + 1;
  localparam int NWIN = 2;                       // 0: high side, 1: low side
  localparam logic [CNT_W-1:0] C_LAST = {CNT_W{1'b1}};
  localparam logic [XW-1:0] C_LAST_X = {1'b0, {CNT_W{1'b1}}};
  localparam logic [XW-1:0] T_X = {1'b1, {CNT_W{1'b0}}};

  logic                 running;
  logic                 first_ld;
  logic                 load;
  logic                 db_new;
  logic [CNT_W-1:0]     sh_int;
  logic [DT_W-1:0]      sh_lead;
  logic [DT_W-1:0]      sh_trail;
  logic                 sh_db;
  logic [CNT_W-1:0]     a_int;
  logic [DT_W-1:0]      a_lead;
  logic [DT_W-1:0]      a_trail;
  logic                 a_db;
  logic [XW-1:0]        d_sum;
  logic [XW-1:0]        d_eff;
  logic [XW-1:0]        ls_lo;
  logic [NWIN-1:0][XW-1:0] win_lo;
  logic [NWIN-1:0][XW-1:0] win_hi;
  logic [NWIN-1:0]      win_hit;
  logic                 gate;

  // Load shadows on the first enabled clock and on the last count of each period.
  assign first_ld = en & ~running;
  assign load     = en & (~running | (count == C_LAST));

`ifdef DPWM_DITHER_EN
  logic [DITH_W-1:0] acc;
  logic [DITH_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, duty_frac};
  assign db_new  = acc_sum[DITH_W];

  // Fractional accumulator: it advances once per load and clears while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc <= '0;
    else if (!en)     acc <= '0;
    else if (load)    acc <= acc_sum[DITH_W-1:0];
  end
`else
  logic unused_frac;
  assign unused_frac = ^duty_frac;
  assign db_new      = 1'b0;
`endif

  // Per-period shadow copies of the duty and dead-time settings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_int   <= '0;
      sh_lead  <= '0;
      sh_trail <= '0;
      sh_db    <= 1'b0;
    end else if (load) begin
      sh_int   <= duty_int;
      sh_lead  <= dt_lead;
      sh_trail <= dt_trail;
      sh_db    <= db_new;
    end
  end

  // Track whether the previous clock was enabled, so the first enabled clock is detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) running <= 1'b0;
    else     running <= en;
  end

  // Period counter: it wraps naturally at 2^CNT_W and is parked at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     count <= '0;
    else if (en) count <= count + 1'b1;
    else         count <= '0;
  end

  // On the first enabled clock, count 0 is being decoded in the same cycle
  // that the shadows load, so the incoming values are used directly.
  // On the last-count load, the old shadows still own c = T-1.
  assign a_int   = first_ld ? duty_int : sh_int;
  assign a_lead  = first_ld ? dt_lead  : sh_lead;
  assign a_trail = first_ld ? dt_trail : sh_trail;
  assign a_db    = first_ld ? db_new   : sh_db;

  // d_eff saturates at T-1, so a full-duty dither carry cannot wrap to 0.
  assign d_sum = XW'(a_int) + XW'(a_db);
  assign d_eff = (d_sum > C_LAST_X) ? C_LAST_X : d_sum;
  assign ls_lo = d_eff + XW'(a_trail);

  assign win_lo[0] = XW'(a_lead);
  assign win_hi[0] = d_eff;
  assign win_lo[1] = ls_lo;
  assign win_hi[1] = T_X;

  genvar g;
  generate
    for (g = 0; g < NWIN; g++) begin : g_win
      dpwm_window #(.W(XW)) u_win (
        .c  ({1'b0, count}),
        .lo (win_lo[g]),
        .hi (win_hi[g]),
        .hit(win_hit[g])
      );
    end
  endgenerate

  // A live fault forces both drives low on the same edge that latches it.
  assign gate = en & ~fault & ~fault_latched;

  // Registered gate drives. The low side is also masked by the high-side hit as a hard interlock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_out <= 1'b0;
      ls_out <= 1'b0;
    end else begin
      hs_out <= gate & win_hit[0];
      ls_out <= gate & win_hit[1] & ~win_hit[0];
    end
  end

  // Fault latch: fault wins over clear, and a clear is honoured only on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   fault_latched <= 1'b0;
    else if (fault)                            fault_latched <= 1'b1;
    else if (fault_clr && (count == C_LAST))   fault_latched <= 1'b0;
  end

  // This signal is combinational, so the very first enabled cycle at count 0 is flagged as well.
  assign period_start = en & ~rst & (count == '0);

endmodule

// File: tb/tb_dpwm_deadtime_dither.sv
// Bench for dpwm_deadtime_dither (CNT_W=6, DITH_W=2, DT_W=4).
module tb_dpwm_deadtime_dither;

  localparam int T = 64;
  localparam int FR = 4;

  logic       clk, rst, en, fault, fault_clr;
  logic [5:0] duty_int;
  logic [1:0] duty_frac;
  logic [3:0] dt_lead, dt_trail;
  logic       hs_out, ls_out, period_start, fault_latched;
  logic [5:0] count;

  dpwm_deadtime_dither #(.CNT_W(6), .DITH_W(2), .DT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .duty_int(duty_int), .duty_frac(duty_frac),
    .dt_lead(dt_lead), .dt_trail(dt_trail), .fault(fault), .fault_clr(fault_clr),
    .hs_out(hs_out), .ls_out(ls_out), .count(count), .period_start(period_start),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference model: per-period parameters captured at period boundaries.
  int m_cnt, m_acc, p_int, p_lead, p_trail, p_db;
  bit m_run, m_flt, e_hs, e_ls;

  task automatic capture();
    p_int = duty_int; p_lead = dt_lead; p_trail = dt_trail;
`ifdef DPWM_DITHER_EN
    m_acc = m_acc + duty_frac;
    p_db  = (m_acc >= FR) ? 1 : 0;
    m_acc = m_acc % FR;
`else
    p_db  = 0;
`endif
  endtask

  always @(posedge clk or posedge rst) begin
    int c, deff;
    if (rst) begin
      m_cnt = 0; m_run = 0; m_acc = 0; m_flt = 0;
      p_int = 0; p_lead = 0; p_trail = 0; p_db = 0; e_hs = 0; e_ls = 0;
    end else begin
      c = m_cnt;
      if (en && !m_run) capture();
      deff = p_int + p_db;
      if (deff > T - 1) deff = T - 1;
      e_hs = en && !m_flt && !fault && (c >= p_lead) && (c < deff);
      e_ls = en && !m_flt && !fault && (c >= deff + p_trail);
      if (en && m_run && c == T - 1) capture();
      if (fault) m_flt = 1;
      else if (fault_clr && c == T - 1) m_flt = 0;
      m_cnt = en ? (c + 1) % T : 0;
      m_run = en;
      if (!en) m_acc = 0;
    end
  end

  typedef struct { int at; int kind; int val; } ev_t;
  ev_t evq[$];

  task automatic push_ev(input int at, input int kind, input int val);
    ev_t e;
    e.at = at; e.kind = kind; e.val = val;
    evq.push_back(e);
  endtask

  // Starting at a count-0 negedge, this task samples one full period of outputs (c=0..63).
  task automatic measure(output int hw, output int lw, output int flc, output int hf);
    hw = 0; lw = 0; flc = 0; hf = -1;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      if (hs_out) begin hw++; if (hf < 0) hf = i; end
      if (ls_out) lw++;
      if (fault_latched) flc++;
      #1;
      foreach (evq[j]) if (evq[j].at == (i + 1) % T) begin
        case (evq[j].kind)
          0: duty_int  = 6'(evq[j].val);
          1: fault     = evq[j].val[0];
          default: fault_clr = evq[j].val[0];
        endcase
      end
    end
    evq.delete();
  endtask

  task automatic sync0();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (count == 0) ok = 1;
    end
    if (!ok) chk("sync0_timeout", 0, 1);
  endtask

  task automatic setp(input int di, input int df, input int ld, input int tr);
    duty_int = 6'(di); duty_frac = 2'(df); dt_lead = 4'(ld); dt_trail = 4'(tr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int hw, lw, flc, hf, n19, ex19;
    bit ok;
    rst = 1; en = 0; fault = 0; fault_clr = 0;
    setp(20, 0, 2, 5);

    fork
      forever begin
        @(negedge clk);
        if (cmp_on && !rst) begin
          chk("cyc_hs", hs_out, e_hs);
          chk("cyc_ls", ls_out, e_ls);
          chk("cyc_cnt", count, m_cnt);
          chk("cyc_ps", period_start, (en && m_cnt == 0) ? 1 : 0);
          chk("cyc_flt", fault_latched, m_flt);
          chk("cyc_overlap", hs_out & ls_out, 0);
        end
      end
    join_none

    #12;
    chk("rst_hs", hs_out, 0); chk("rst_ls", ls_out, 0); chk("rst_cnt", count, 0);
    chk("rst_ps", period_start, 0); chk("rst_flt", fault_latched, 0);

    @(negedge clk); #1 rst = 0; cmp_on = 1;
    repeat (3) @(negedge clk);
    chk("dis_cnt", count, 0);
    #1 en = 1;

    // The first period after enable uses the freshly loaded settings.
    measure(hw, lw, flc, hf);
    chk("base_hw", hw, 18); chk("base_lw", lw, 39); chk("base_hf", hf, 2);
    measure(hw, lw, flc, hf);
    chk("base2_hw", hw, 18); chk("base2_lw", lw, 39);

    // A mid-period duty change takes effect in the next period.
    push_ev(10, 0, 40);
    measure(hw, lw, flc, hf);
    chk("chg_cur_hw", hw, 18);
    measure(hw, lw, flc, hf);
    chk("chg_nxt_hw", hw, 38); chk("chg_nxt_lw", lw, 19);

    // Full duty saturates at T-1, so the low side stays off.
    #1 setp(63, 3, 2, 1);
    measure(hw, lw, flc, hf);
    measure(hw, lw, flc, hf);
    chk("sat_hw", hw, 61); chk("sat_lw", lw, 0);

    // The low-side window collapses to the single count T-1.
    #1 setp(58, 0, 2, 5);
    measure(hw, lw, flc, hf);
    measure(hw, lw, flc, hf);
    chk("edge_hw", hw, 56); chk("edge_lw", lw, 1);

    // An empty high-side window gives constant 0.
    #1 setp(10, 0, 10, 0);
    measure(hw, lw, flc, hf);
    measure(hw, lw, flc, hf);
    chk("empty_hw", hw, 0); chk("empty_lw", lw, 54);

    // Dither pattern over 4 periods.
    #1 setp(20, 1, 2, 5);
    measure(hw, lw, flc, hf);
`ifdef DPWM_DITHER_EN
    ex19 = 1;
`else
    ex19 = 0;
`endif
    n19 = 0;
    for (int p = 0; p < 4; p++) begin
      measure(hw, lw, flc, hf);
      if (hw == 19) n19++;
      else chk("dith1_w18", hw, 18);
    end
    chk("dith1_n19", n19, ex19);
    #1 setp(20, 3, 2, 5);
    measure(hw, lw, flc, hf);
`ifdef DPWM_DITHER_EN
    ex19 = 3;
`else
    ex19 = 0;
`endif
    n19 = 0;
    for (int p = 0; p < 4; p++) begin
      measure(hw, lw, flc, hf);
      if (hw == 19) n19++;
      else chk("dith3_w18", hw, 18);
    end
    chk("dith3_n19", n19, ex19);

    // Fault pulse, followed by an ignored clear and then an honoured clear.
    #1 setp(20, 0, 2, 5);
    measure(hw, lw, flc, hf);
    push_ev(15, 1, 1); push_ev(16, 1, 0);
    push_ev(30, 2, 1); push_ev(31, 2, 0);
    push_ev(63, 2, 1); push_ev(0, 2, 0);
    measure(hw, lw, flc, hf);
    chk("flt_hw", hw, 13); chk("flt_lw", lw, 0); chk("flt_cycles", flc, 48);
    measure(hw, lw, flc, hf);
    chk("flt_resume_hw", hw, 18); chk("flt_resume_lw", lw, 39); chk("flt_resume_fl", flc, 0);

    // Fault and clear asserted together at T-1: the fault wins.
    push_ev(63, 1, 1); push_ev(63, 2, 1); push_ev(0, 1, 0); push_ev(0, 2, 0);
    measure(hw, lw, flc, hf);
    chk("both_hw", hw, 18); chk("both_lw", lw, 38); chk("both_fl", flc, 1);
    push_ev(63, 2, 1); push_ev(0, 2, 0);
    measure(hw, lw, flc, hf);
    chk("held_hw", hw, 0); chk("held_lw", lw, 0); chk("held_fl", flc, 63);
    measure(hw, lw, flc, hf);
    chk("clr_hw", hw, 18); chk("clr_lw", lw, 39);

    // Disable mid-period, then re-enable.
    repeat (5) @(negedge clk);
    #1 en = 0;
    repeat (4) @(negedge clk);
    chk("en0_cnt", count, 0); chk("en0_hs", hs_out, 0); chk("en0_ls", ls_out, 0);
    #1 en = 1;
    measure(hw, lw, flc, hf);
    chk("reen_hw", hw, 18); chk("reen_lw", lw, 39);

    // Asynchronous reset while hs_out is high.
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (count == 12) ok = 1;
    end
    chk("rst_wait", ok, 1);
    chk("pre_rst_hs", hs_out, 1);
    #2 rst = 1;
    #1;
    chk("arst_hs", hs_out, 0); chk("arst_ls", ls_out, 0); chk("arst_cnt", count, 0);
    chk("arst_ps", period_start, 0); chk("arst_flt", fault_latched, 0);
    @(negedge clk); #1 rst = 0;
    #1;
    chk("rel_cnt", count, 0); chk("rel_ps", period_start, 1);
    measure(hw, lw, flc, hf);
    chk("rel_hw", hw, 18); chk("rel_lw", lw, 39); chk("rel_hf", hf, 2);

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpwm_deadtime_dither.md
DPWM_DEADTIME_DITHER -- requirements
Module: dpwm_deadtime_dither

Interface
REQ-001 Parameter CNT_W, default 6: period counter width; period T = 2^CNT_W clocks.
REQ-002 Parameter DITH_W, default 2: duty fractional (dither) bits.
REQ-003 Parameter DT_W, default 4: dead-time field width, in clocks.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports in this order: clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-high reset).
REQ-005 en  in  1  run enable.
REQ-006 duty_int  in  CNT_W  integer duty, in clocks.
REQ-007 duty_frac  in  DITH_W  fractional duty, in units of 1/2^DITH_W clock.
REQ-008 dt_lead  in  DT_W  dead time before hs_out rises.
REQ-009 dt_trail  in  DT_W  dead time after hs_out falls, before ls_out rises.
REQ-010 fault  in  1  fault request, level-sensitive.
REQ-011 fault_clr  in  1  fault clear request.
REQ-012 hs_out  out  1  high-side gate drive.
REQ-013 ls_out  out  1  low-side gate drive.
REQ-014 count  out  CNT_W  period counter.
REQ-015 period_start  out  1  one-clock pulse in the cycle where count==0.
REQ-016 fault_latched  out  1  latched fault status.

Function
REQ-017 While en=1, count SHALL increment each clock and wrap from T-1 to 0. While en=0, count SHALL be held at 0, both outputs SHALL be 0, and the dither accumulator SHALL be cleared.
REQ-018 Shadow registers for duty_int, duty_frac, dt_lead and dt_trail SHALL load only in the clock where count==T-1, or on the first enabled clock after en rises; mid-period input changes SHALL have no effect until the next period.
REQ-019 At each load, acc(DITH_W bits) <= acc + duty_frac; the carry-out SHALL be dither bit db for the coming period.
REQ-020 d_eff = min(duty_int + db, T-1), computed in CNT_W+1 bits; d_eff SHALL never wrap to 0.
REQ-021 hs_out SHALL be 1 for count values c in the range dt_lead <= c < d_eff.
REQ-022 ls_out SHALL be 1 for count values c in the range d_eff + dt_trail <= c <= T-1, with the sum computed in CNT_W+1 bits.
REQ-023 Empty ranges SHALL give a constant 0 for the whole period: hs_out when dt_lead >= d_eff, ls_out when d_eff + dt_trail > T-1.
REQ-024 Outputs SHALL be registered: each output value is driven in the clock following the clock in which count equals c (fixed latency of 1 clock).
REQ-025 hs_out and ls_out SHALL never be 1 in the same clock, for any input combination.
REQ-026 fault=1 SHALL set fault_latched on the next edge, and both outputs SHALL be 0 from that edge onward.
REQ-027 The counter and dither SHALL keep running while fault_latched=1.
REQ-028 fault_clr SHALL clear fault_latched only in the clock where count==T-1 and fault=0; fault_clr at any other time SHALL be ignored.
REQ-029 If fault and fault_clr are both 1 in the same clock, fault SHALL win.

Reset
REQ-030 rst=1 SHALL asynchronously force count=0, hs_out=0, ls_out=0, period_start=0, fault_latched=0, acc=0 and all shadow registers=0.
REQ-031 Reset asserted mid-period SHALL abort the period immediately.
REQ-032 After reset release with en=1, shadows SHALL load on the first clock.

Configuration
REQ-033 With macro DPWM_DITHER_EN defined, REQ-019 SHALL apply and duty_frac SHALL be used.
REQ-034 Without DPWM_DITHER_EN, the accumulator logic SHALL be absent, duty_frac SHALL be ignored, and db SHALL be 0.

Verification (CNT_W=6, DITH_W=2, DT_W=4)
REQ-035 duty_int=20, duty_frac=0, dt_lead=2, dt_trail=5 -> per 64-clock period, hs_out is high 18 clocks (c=2..19), ls_out is high 39 clocks (c=25..63), with zero overlap.
REQ-036 DPWM_DITHER_EN defined, duty_int=20, duty_frac=1 -> exactly 1 of every 4 consecutive periods has hs_out width 19, the others 18; with duty_frac=3, 3 of every 4 periods have width 19.
REQ-037 duty_int=63, duty_frac=3, dt_trail=1 -> d_eff=63 (no wrap), and ls_out stays 0 for the whole period.
REQ-038 duty_int changed from 20 to 40 at count=10 -> the current period keeps width 18, and the next period has hs_out width 38.
REQ-039 fault pulsed at count=15 -> both outputs are 0 from the next clock; fault_clr at count=30 is ignored; fault_clr at count=63 clears fault_latched, and outputs resume in the following period.
REQ-040 rst asserted at count=12 while hs_out=1 -> all outputs are 0 with no clock edge needed; after release, the sequence restarts at count=0.
